// File: rtl/pio_mem_req_ctl_pkg.sv
// Shared types and defines for the PIO memory request controller.
// Provides PIO_NBITS/PIO_RANGE/CLK_RST/RESET_SIG unless the build already defines them.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif
`ifndef PIO_RANGE
`define PIO_RANGE `PIO_NBITS-1:0
`endif
`ifndef CLK_RST
`define CLK_RST posedge clk or negedge rst_n
`endif
`ifndef RESET_SIG
`define RESET_SIG input logic rst_n
`endif

package pio_mem_req_ctl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } pio_state_e;

   localparam logic [`PIO_RANGE] PIO_ERR_DATA_DFLT = 32'hDEAD_BEEF;

   // A single memory needs no select bits; keep the index at least one bit wide.
   function automatic int sel_width(input int num_mem);
      return (num_mem > 1) ? $clog2(num_mem) : 1;
   endfunction

endpackage

// File: rtl/pio_mem_sel_mux.sv
// One-hot decode of the host select field and ack/read-data slice mux
// driven by the latched one-hot select.
module pio_mem_sel_mux
   import pio_mem_req_ctl_pkg::*;
#(
   parameter int NUM_MEM = 4,
   parameter int SEL_W   = sel_width(NUM_MEM)
) (
   input  logic [SEL_W-1:0]              dec_idx,
   output logic [NUM_MEM-1:0]            dec_onehot,
   output logic                          dec_valid,
   input  logic [NUM_MEM-1:0]            mux_ms,
   input  logic [NUM_MEM-1:0]            mem_ack,
   input  logic [NUM_MEM*`PIO_NBITS-1:0] mem_rdata,
   output logic                          ack_sel,
   output logic [`PIO_RANGE]             rdata_sel
);

   always_comb begin
      dec_onehot = '0;
      for (int i = 0; i < NUM_MEM; i++) begin
         dec_onehot[i] = (NUM_MEM == 1) || (32'(dec_idx) == 32'(i));
      end
   end

   assign dec_valid = (NUM_MEM == 1) || (32'(dec_idx) < 32'(NUM_MEM));

   // Select is one-hot, so at most one slice wins; no select yields zeros.
   always_comb begin
      ack_sel   = 1'b0;
      rdata_sel = '0;
      for (int i = 0; i < NUM_MEM; i++) begin
         if (mux_ms[i]) begin
            ack_sel   = mem_ack[i];
            rdata_sel = mem_rdata[i*`PIO_NBITS +: `PIO_NBITS];
         end
      end
   end

endmodule

// File: rtl/pio_mem_req_ctl.sv
// PIO request controller: one host read/write at a time, strobed to the selected BRAM wrapper.
// Optional ack-wait timeout enabled by defining PIO_MEM_REQ_TIMEOUT_EN.
module pio_mem_req_ctl
   import pio_mem_req_ctl_pkg::*;
#(
   parameter int                NUM_MEM       = 4,
   parameter int                SEL_LSB       = 12,
   parameter int                TIMEOUT_NBITS = 10,
   parameter logic [`PIO_RANGE] ERR_DATA      = PIO_ERR_DATA_DFLT
) (
   input  logic                          clk,
   `RESET_SIG,
   input  logic                          clk_div,
   input  logic [`PIO_RANGE]             pio_addr,
   input  logic [`PIO_RANGE]             pio_wdata,
   input  logic                          pio_rd,
   input  logic                          pio_wr,
   output logic                          pio_ack,
   output logic                          pio_err,
   output logic [`PIO_RANGE]             pio_rdata,
   output logic                          pio_busy,
   output logic [`PIO_RANGE]             reg_addr,
   output logic [`PIO_RANGE]             reg_din,
   output logic                          reg_rd,
   output logic                          reg_wr,
   output logic [NUM_MEM-1:0]            reg_ms,
   input  logic [NUM_MEM-1:0]            mem_ack,
   input  logic [NUM_MEM*`PIO_NBITS-1:0] mem_rdata
);

   localparam int SEL_W = sel_width(NUM_MEM);

   pio_state_e          state;
   logic                is_wr;
   logic                ack_prev;
   logic [SEL_W-1:0]    dec_idx;
   logic [NUM_MEM-1:0]  dec_onehot;
   logic                dec_valid;
   logic                ack_sel;
   logic [`PIO_RANGE]   rdata_sel;

   assign dec_idx = pio_addr[SEL_LSB +: SEL_W];

   pio_mem_sel_mux #(
      .NUM_MEM (NUM_MEM),
      .SEL_W   (SEL_W)
   ) u_sel_mux (
      .dec_idx    (dec_idx),
      .dec_onehot (dec_onehot),
      .dec_valid  (dec_valid),
      .mux_ms     (reg_ms),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .ack_sel    (ack_sel),
      .rdata_sel  (rdata_sel)
   );

`ifdef PIO_MEM_REQ_TIMEOUT_EN
   logic [TIMEOUT_NBITS-1:0] tmo_cnt;
`else
   logic                     unused_clk_div;
   logic [TIMEOUT_NBITS-1:0] unused_tmo_cnt;
   assign unused_clk_div = clk_div;
   assign unused_tmo_cnt = '0;
`endif

   always_ff @(`CLK_RST) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         is_wr     <= 1'b0;
         ack_prev  <= 1'b0;
`ifdef PIO_MEM_REQ_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
         pio_ack   <= 1'b0;
         pio_err   <= 1'b0;
         pio_rdata <= '0;
         pio_busy  <= 1'b0;
         reg_addr  <= '0;
         reg_din   <= '0;
         reg_rd    <= 1'b0;
         reg_wr    <= 1'b0;
         reg_ms    <= '0;
      end else begin
         pio_ack <= 1'b0;
         pio_err <= 1'b0;
         reg_rd  <= 1'b0;
         reg_wr  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pio_rd || pio_wr) begin
                  reg_addr <= pio_addr;
                  reg_din  <= pio_wdata;
                  is_wr    <= pio_wr;
                  pio_busy <= 1'b1;
                  if (dec_valid) begin
                     reg_ms <= dec_onehot;
                     reg_wr <= pio_wr;
                     reg_rd <= !pio_wr;
                     state  <= ST_ISSUE;
                  end else begin
                     pio_ack   <= 1'b1;
                     pio_err   <= 1'b1;
                     pio_rdata <= ERR_DATA;
                     state     <= ST_RESP;
                  end
               end
            end
            // Sampling the ack here marks a level already high at WAIT entry as stale.
            ST_ISSUE: begin
               ack_prev <= ack_sel;
`ifdef PIO_MEM_REQ_TIMEOUT_EN
               tmo_cnt  <= '0;
`endif
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               ack_prev <= ack_sel;
               if (ack_sel && !ack_prev) begin
                  pio_ack   <= 1'b1;
                  pio_rdata <= is_wr ? '0 : rdata_sel;
                  state     <= ST_RESP;
               end
`ifdef PIO_MEM_REQ_TIMEOUT_EN
               else if (&tmo_cnt) begin
                  pio_ack   <= 1'b1;
                  pio_err   <= 1'b1;
                  pio_rdata <= ERR_DATA;
                  state     <= ST_RESP;
               end else if (clk_div) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            ST_RESP: begin
               pio_rdata <= '0;
               pio_busy  <= 1'b0;
               reg_ms    <= '0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pio_mem_req_ctl.sv
// Self-checking bench for pio_mem_req_ctl: directed scenarios plus randomized transactions
// against a transaction-level expectation (select, strobe, completion cycle, data, error).
module tb_pio_mem_req_ctl;

   localparam int          NM   = 3;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clk_div = 1'b0;
   logic [31:0]   pio_addr = '0;
   logic [31:0]   pio_wdata = '0;
   logic          pio_rd = 1'b0;
   logic          pio_wr = 1'b0;
   logic          pio_ack;
   logic          pio_err;
   logic [31:0]   pio_rdata;
   logic          pio_busy;
   logic [31:0]   reg_addr;
   logic [31:0]   reg_din;
   logic          reg_rd;
   logic          reg_wr;
   logic [NM-1:0] reg_ms;
   logic [NM-1:0] mem_ack = '0;
   logic [NM*32-1:0] mem_rdata = '0;

   int vectors = 0;
   int miscompares = 0;

   pio_mem_req_ctl #(
      .NUM_MEM       (NM),
      .SEL_LSB       (12),
      .TIMEOUT_NBITS (4),
      .ERR_DATA      (ERRD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk_div   (clk_div),
      .pio_addr  (pio_addr),
      .pio_wdata (pio_wdata),
      .pio_rd    (pio_rd),
      .pio_wr    (pio_wr),
      .pio_ack   (pio_ack),
      .pio_err   (pio_err),
      .pio_rdata (pio_rdata),
      .pio_busy  (pio_busy),
      .reg_addr  (reg_addr),
      .reg_din   (reg_din),
      .reg_rd    (reg_rd),
      .reg_wr    (reg_wr),
      .reg_ms    (reg_ms),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) clk_div <= ~clk_div;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ack"}, {31'b0, pio_ack}, 32'h0);
      chk({tag, "_err"}, {31'b0, pio_err}, 32'h0);
      chk({tag, "_rdata"}, pio_rdata, 32'h0);
      chk({tag, "_busy"}, {31'b0, pio_busy}, 32'h0);
      chk({tag, "_strobe"}, {30'b0, reg_rd, reg_wr}, 32'h0);
      chk({tag, "_ms"}, 32'(reg_ms), 32'h0);
   endtask

   // One host transaction. The memory model raises the selected ack `dly` cycles after
   // the strobe (or, when stale, holds it high first, drops it, then re-raises it).
   task automatic txn(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rdat, input int dly,
                      input bit stale, input bit poke);
      int          sel = int'(addr[13:12]);
      bit          valid = (sel < NM);
      logic [NM-1:0] ems = valid ? NM'(1 << sel) : '0;
      logic [31:0] erd = !valid ? ERRD : (wr ? 32'h0 : rdat);
      int          drop_cyc = stale ? 2 + dly : -1;
      int          rise_cyc = stale ? 4 + dly : 1 + dly;
      int          exp_ack_cyc = valid ? rise_cyc + 1 : 1;
      int          n_strb = 0;
      int          strb_cyc = -1;
      int          ack_cyc = -1;
      int          extra = 0;
      bit          strb_wr = 1'b0;
      bit          ack_err = 1'b0;
      logic [31:0] ack_data = '0;
      logic [NM-1:0] ack_ms = '0;

      mem_ack = '0;
      if (valid && stale) begin
         mem_ack[sel] = 1'b1;
         mem_rdata[sel*32 +: 32] = ~rdat;
      end
      pio_addr  = addr;
      pio_wdata = wd;
      pio_rd    = rd;
      pio_wr    = wr;
      for (int c = 1; c <= 60 && ack_cyc < 0; c++) begin
         tick();
         pio_rd = 1'b0;
         pio_wr = 1'b0;
         if (c == 1) begin
            chk({tag, "_busy"}, {31'b0, pio_busy}, 32'h1);
            chk({tag, "_addr"}, reg_addr, addr);
            chk({tag, "_din"}, reg_din, wd);
            chk({tag, "_ms"}, 32'(reg_ms), 32'(ems));
         end
         if (reg_rd || reg_wr) begin
            n_strb   = n_strb + int'(reg_rd) + int'(reg_wr);
            strb_cyc = c;
            strb_wr  = reg_wr;
         end
         if (pio_ack) begin
            ack_cyc  = c;
            ack_err  = pio_err;
            ack_data = pio_rdata;
            ack_ms   = reg_ms;
         end
         if (poke && c == 2) begin
            pio_wr   = 1'b1;
            pio_addr = addr ^ 32'h0000_1000;
         end
         for (int i = 0; i < NM; i++) begin
            if (!valid || i != sel) begin
               mem_ack[i] = 1'($urandom_range(0, 1));
               mem_rdata[i*32 +: 32] = $urandom;
            end
         end
         if (valid && c == drop_cyc) mem_ack[sel] = 1'b0;
         if (valid && c == rise_cyc) begin
            mem_ack[sel] = 1'b1;
            mem_rdata[sel*32 +: 32] = rdat;
         end
      end
      chk({tag, "_ack_cycle"}, 32'(ack_cyc), 32'(exp_ack_cyc));
      chk({tag, "_n_strobe"}, 32'(n_strb), valid ? 32'h1 : 32'h0);
      chk({tag, "_strobe_cycle"}, 32'(strb_cyc), valid ? 32'h1 : 32'hFFFF_FFFF);
      chk({tag, "_strobe_dir"}, {31'b0, strb_wr}, {31'b0, valid & wr});
      chk({tag, "_err"}, {31'b0, ack_err}, {31'b0, !valid});
      chk({tag, "_rdata"}, ack_data, erd);
      chk({tag, "_ms_held"}, 32'(ack_ms), 32'(ems));
      mem_ack = '0;
      tick();
      chk_quiet({tag, "_post"});
      for (int c = 0; c < 3; c++) begin
         tick();
         extra = extra + int'(pio_ack) + int'(reg_rd) + int'(reg_wr);
      end
      chk({tag, "_no_extra"}, 32'(extra), 32'h0);
   endtask

   initial begin
      int n_ack;

      // Reset state
      repeat (3) tick();
      chk_quiet("reset");
      rst_n = 1'b1;
      tick();

      // Directed scenarios
      txn("wr_mem1", 1'b0, 1'b1, 32'h0000_1008, 32'hA5A5_0001, 32'h0, 3, 1'b0, 1'b0);
      txn("rd_mem2", 1'b1, 1'b0, 32'h0000_2010, 32'h0, 32'h1234_5678, 2, 1'b0, 1'b0);
      txn("stale_mem0", 1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 1'b0);
      txn("bad_sel_wr", 1'b0, 1'b1, 32'h0000_3000, 32'h1111_2222, 32'h0, 1, 1'b0, 1'b0);
      txn("bad_sel_rd", 1'b1, 1'b0, 32'h0000_3ABC, 32'h0, 32'h0, 1, 1'b0, 1'b0);
      txn("rd_wr_both", 1'b1, 1'b1, 32'h0000_1FFC, 32'h0BAD_C0DE, 32'h7777_8888, 1, 1'b0, 1'b1);

`ifdef PIO_MEM_REQ_TIMEOUT_EN
      // Timeout: no ack ever arrives
      begin
         int ac;
         ac = -1;
         pio_addr = 32'h0000_0040;
         pio_rd   = 1'b1;
         for (int c = 1; c <= 80 && ac < 0; c++) begin
            tick();
            pio_rd = 1'b0;
            if (pio_ack) begin
               ac = c;
               chk("tmo_err", {31'b0, pio_err}, 32'h1);
               chk("tmo_rdata", pio_rdata, ERRD);
            end
         end
         chk("tmo_window", {31'b0, (ac >= 31 && ac <= 35)}, 32'h1);
         tick();
         chk_quiet("tmo_post");
      end
`else
      // Without a timeout the controller waits indefinitely, then completes on the ack edge
      begin
         n_ack = 0;
         pio_addr = 32'h0000_1040;
         pio_rd   = 1'b1;
         for (int c = 1; c <= 60; c++) begin
            tick();
            pio_rd = 1'b0;
            n_ack += int'(pio_ack);
         end
         chk("nowait_no_ack", 32'(n_ack), 32'h0);
         chk("nowait_busy", {31'b0, pio_busy}, 32'h1);
         mem_ack[1] = 1'b1;
         mem_rdata[32 +: 32] = 32'h5EED_0001;
         tick();
         chk("nowait_ack", {31'b0, pio_ack}, 32'h1);
         chk("nowait_err", {31'b0, pio_err}, 32'h0);
         chk("nowait_rdata", pio_rdata, 32'h5EED_0001);
         mem_ack = '0;
         tick();
         chk_quiet("nowait_post");
      end
`endif

      // Reset mid-WAIT with a second request dropped while busy
      begin
         n_ack = 0;
         pio_addr = 32'h0000_1100;
         pio_rd   = 1'b1;
         tick();
         pio_rd = 1'b0;
         tick();
         pio_addr = 32'h0000_2200;
         pio_wr   = 1'b1;
         tick();
         pio_wr = 1'b0;
         chk("busy_drop_ms", 32'(reg_ms), 32'h2);
         chk("busy_drop_addr", reg_addr, 32'h0000_1100);
         chk("busy_drop_strobe", {30'b0, reg_rd, reg_wr}, 32'h0);
         tick();
         #2 rst_n = 1'b0;
         #1;
         chk_quiet("async_rst");
         tick();
         tick();
         rst_n = 1'b1;
         for (int c = 0; c < 6; c++) begin
            tick();
            n_ack = n_ack + int'(pio_ack) + int'(reg_rd) + int'(reg_wr) + int'(pio_busy);
         end
         chk("rst_no_activity", 32'(n_ack), 32'h0);
      end

      // Randomized transactions
      for (int k = 0; k < 16; k++) begin
         logic [31:0] a;
         bit          r;
         bit          w;
         a = {18'($urandom), 2'($urandom_range(0, 3)), 12'($urandom)};
         r = 1'($urandom_range(0, 1));
         w = r ? 1'($urandom_range(0, 1)) : 1'b1;
         txn($sformatf("rnd%0d", k), r, w, a, $urandom, $urandom, int'($urandom_range(1, 6)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
